// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions for the memory stage: bus widths, FSM encoding
// and the word-alignment helper used when forming bus addresses.
package rv_pipe_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;

    localparam logic [XLEN-1:0] WORD_ALIGN_MASK   = 32'hFFFF_FFFC;
    localparam logic [XLEN-1:0] ERR_RDATA_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mau_state_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] byte_addr);
        return byte_addr & WORD_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Word-wide req/ack data bus between the memory-stage master and the
// data-memory responder.
interface mem_access_unit_if;
    import rv_pipe_pkg::*;

    logic            req;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic            ack;
    logic [XLEN-1:0] rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);

endinterface

// File: rtl/mem_timeout_ctr.sv
// Cycle counter for an outstanding bus access; terminal asserts on the last
// cycle the access may wait before it is aborted.
module mem_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign terminal = (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage bus master: turns M-stage loads/stores into req/ack bus
// accesses, stalls the pipeline while one is outstanding, and owns M/W.
module mem_access_unit
    import rv_pipe_pkg::*;
#(
    parameter int              TIMEOUT_CYCLES = 16,
    parameter logic [XLEN-1:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 RegWriteM,
    input  logic                 ResultSrcM,
    input  logic                 MemWriteM,
    input  logic [XLEN-1:0]      ALUResultM,
    input  logic [XLEN-1:0]      WriteDataM,
    input  logic [REG_IDX_W-1:0] RdM,
    output logic                 StallM,
    mem_access_unit_if.master    bus,
    output logic                 BusErr,
    output logic                 RegWriteW,
    output logic                 ResultSrcW,
    output logic [XLEN-1:0]      ALUResultW,
    output logic [XLEN-1:0]      ReadDataW,
    output logic [REG_IDX_W-1:0] RdW
);

    mau_state_t      state;
    logic [XLEN-1:0] rdata_q;
    logic            access;
    logic            in_busy;
    logic            timeout_hit;

    assign access  = ResultSrcM | MemWriteM;
    assign in_busy = (state == ST_BUSY);
    assign StallM  = ((state == ST_IDLE) && access) || in_busy;

    mem_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (!in_busy),
        .enable   (in_busy && !bus.ack),
        .terminal (timeout_hit)
    );

    // Access FSM; bus fields only change on entry to BUSY so they stay stable while req is up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            bus.req   <= 1'b0;
            bus.we    <= 1'b0;
            bus.addr  <= '0;
            bus.wdata <= '0;
            BusErr    <= 1'b0;
            rdata_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (access) begin
                        state     <= ST_BUSY;
                        bus.req   <= 1'b1;
                        bus.we    <= MemWriteM;
                        bus.addr  <= word_align(ALUResultM);
                        bus.wdata <= WriteDataM;
                    end
                end
                ST_BUSY: begin
                    if (bus.ack) begin
                        state   <= ST_DONE;
                        bus.req <= 1'b0;
                        if (!bus.we) begin
                            rdata_q <= bus.rdata;
                        end
                    end else if (timeout_hit) begin
                        state   <= ST_DONE;
                        bus.req <= 1'b0;
                        BusErr  <= 1'b1;
                        rdata_q <= ERR_RDATA;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state   <= ST_IDLE;
                    bus.req <= 1'b0;
                end
            endcase
        end
    end

    // M/W register: bubble while stalled, retire the held instruction when released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= 1'b0;
            ALUResultW <= '0;
            ReadDataW  <= '0;
            RdW        <= '0;
        end else if (StallM) begin
            RegWriteW <= 1'b0;
            RdW       <= '0;
        end else begin
            RegWriteW  <= RegWriteM;
            ResultSrcW <= ResultSrcM;
            ALUResultW <= ALUResultM;
            RdW        <= RdM;
            if (state == ST_DONE) begin
                ReadDataW <= rdata_q;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboarded bench for mem_access_unit with a configurable-latency bus responder.
module tb_mem_access_unit;
    import rv_pipe_pkg::*;

    localparam int              TOUT = 16;
    localparam logic [XLEN-1:0] ERRV = 32'hDEAD_BEEF;

    typedef struct {
        logic        rw;
        logic        rs;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [4:0]  rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RegWriteM = 1'b0, ResultSrcM = 1'b0, MemWriteM = 1'b0;
    logic [31:0] ALUResultM = '0, WriteDataM = '0;
    logic [4:0]  RdM = '0;
    logic        StallM, BusErr, RegWriteW, ResultSrcW;
    logic [31:0] ALUResultW, ReadDataW;
    logic [4:0]  RdW;

    int total = 0;
    int bad = 0;
    exp_t sb[$];
    logic [31:0] model_rdq = '0;
    logic [31:0] model_rdw = '0;

    // responder controls and observations
    int          ack_delay = 0;
    logic [31:0] ack_data = '0;
    logic        stray_ack = 1'b0;
    int          busy_n = 0;
    logic        obs_we = 1'b0;
    logic [31:0] obs_addr = '0, obs_wdata = '0;
    logic        bus_stable = 1'b1;

    mem_access_unit_if bus ();

    mem_access_unit #(
        .TIMEOUT_CYCLES (TOUT),
        .ERR_RDATA      (ERRV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .RegWriteM  (RegWriteM),
        .ResultSrcM (ResultSrcM),
        .MemWriteM  (MemWriteM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .RdM        (RdM),
        .StallM     (StallM),
        .bus        (bus.master),
        .BusErr     (BusErr),
        .RegWriteW  (RegWriteW),
        .ResultSrcW (ResultSrcW),
        .ALUResultW (ALUResultW),
        .ReadDataW  (ReadDataW),
        .RdW        (RdW)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.req === 1'b1 && busy_n == 0) begin
            busy_n     = 1;
            obs_addr   = bus.addr;
            obs_we     = bus.we;
            obs_wdata  = bus.wdata;
            bus_stable = 1'b1;
        end else if (bus.req === 1'b1) begin
            busy_n = busy_n + 1;
            if (bus.addr !== obs_addr || bus.we !== obs_we || bus.wdata !== obs_wdata)
                bus_stable = 1'b0;
        end else begin
            busy_n = 0;
        end
        bus.ack   = stray_ack || (bus.req === 1'b1 && ack_delay != 0 && busy_n == ack_delay);
        bus.rdata = ack_data;
    end

    task automatic set_idle();
        RegWriteM = 1'b0; ResultSrcM = 1'b0; MemWriteM = 1'b0;
        ALUResultM = '0; WriteDataM = '0; RdM = '0;
    endtask

    // Present one instruction, hold it while stalled, then score the retired M/W values.
    task automatic run_instr(input logic rw, input logic rs, input logic mw,
                             input logic [31:0] alu, input logic [31:0] wd,
                             input logic [4:0] rd, input int delay,
                             input logic [31:0] rdv, output int stalls);
        exp_t e, got;
        @(negedge clk);
        ack_delay = delay;
        ack_data  = rdv;
        RegWriteM = rw; ResultSrcM = rs; MemWriteM = mw;
        ALUResultM = alu; WriteDataM = wd; RdM = rd;
        if (rs | mw) begin
            if (delay == 0)  model_rdq = ERRV;
            else if (!mw)    model_rdq = rdv;
            model_rdw = model_rdq;
        end
        e.rw = rw; e.rs = rs; e.alu = alu; e.rdata = model_rdw; e.rd = rd;
        sb.push_back(e);
        #1;
        stalls = 0;
        while (StallM === 1'b1 && stalls < 200) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        if (stalls > 0) begin
            total++;
            if (RdW !== 5'd0 || RegWriteW !== 1'b0) begin
                bad++;
                $display("FAIL bubble: RdW=%0d RegWriteW=%b required 0/0", RdW, RegWriteW);
            end
        end
        @(posedge clk);
        #1;
        got = sb.pop_front();
        total++;
        if (RegWriteW !== got.rw || ResultSrcW !== got.rs || ALUResultW !== got.alu ||
            ReadDataW !== got.rdata || RdW !== got.rd) begin
            bad++;
            $display("FAIL writeback: got rw=%b rs=%b alu=%h rdata=%h rd=%0d required rw=%b rs=%b alu=%h rdata=%h rd=%0d",
                     RegWriteW, ResultSrcW, ALUResultW, ReadDataW, RdW,
                     got.rw, got.rs, got.alu, got.rdata, got.rd);
        end
        set_idle();
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (StallM !== 1'b0 || bus.req !== 1'b0 || bus.we !== 1'b0 || bus.addr !== '0 ||
            bus.wdata !== '0 || BusErr !== 1'b0 || RegWriteW !== 1'b0 || ResultSrcW !== 1'b0 ||
            ALUResultW !== '0 || ReadDataW !== '0 || RdW !== '0) begin
            bad++;
            $display("FAIL reset_state: req=%b we=%b addr=%h err=%b rw=%b rd=%0d required all zero",
                     bus.req, bus.we, bus.addr, BusErr, RegWriteW, RdW);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_alu();
        int st;
        run_instr(1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd5, 1, 32'h0, st);
        total++;
        if (st !== 0) begin
            bad++;
            $display("FAIL alu_stall: got %0d cycles required 0", st);
        end
    endtask

    task automatic test_load();
        int st;
        run_instr(1'b1, 1'b1, 1'b0, 32'h103, 32'h0, 5'd7, 3, 32'hCAFE_F00D, st);
        total++;
        if (st !== 4) begin
            bad++;
            $display("FAIL load_stall: got %0d cycles required 4", st);
        end
        total++;
        if (obs_addr !== 32'h100 || obs_we !== 1'b0 || bus_stable !== 1'b1) begin
            bad++;
            $display("FAIL load_bus: addr=%h we=%b stable=%b required 100/0/1", obs_addr, obs_we, bus_stable);
        end
    endtask

    task automatic test_store();
        int st;
        run_instr(1'b0, 1'b0, 1'b1, 32'h200, 32'hA5A5_A5A5, 5'd0, 1, 32'h1111_2222, st);
        total++;
        if (st !== 2) begin
            bad++;
            $display("FAIL store_stall: got %0d cycles required 2", st);
        end
        total++;
        if (obs_addr !== 32'h200 || obs_we !== 1'b1 || obs_wdata !== 32'hA5A5_A5A5) begin
            bad++;
            $display("FAIL store_bus: addr=%h we=%b wdata=%h required 200/1/a5a5a5a5", obs_addr, obs_we, obs_wdata);
        end
    endtask

    task automatic test_timeout();
        int st;
        total++;
        if (BusErr !== 1'b0) begin
            bad++;
            $display("FAIL err_before_timeout: got %b required 0", BusErr);
        end
        run_instr(1'b1, 1'b1, 1'b0, 32'h3F8, 32'h0, 5'd9, 0, 32'h0, st);
        total++;
        if (st !== TOUT + 1) begin
            bad++;
            $display("FAIL timeout_stall: got %0d cycles required %0d", st, TOUT + 1);
        end
        total++;
        if (BusErr !== 1'b1 || bus.req !== 1'b0 || bus_stable !== 1'b1) begin
            bad++;
            $display("FAIL timeout_flags: err=%b req=%b stable=%b required 1/0/1", BusErr, bus.req, bus_stable);
        end
    endtask

    task automatic test_back_to_back();
        int st1, st2;
        run_instr(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 5'd3, 2, 32'h0BAD_CAFE, st1);
        run_instr(1'b0, 1'b0, 1'b1, 32'h46, 32'h5555_0000, 5'd0, 1, 32'h7777_7777, st2);
        total++;
        if (st1 !== 3 || st2 !== 2) begin
            bad++;
            $display("FAIL b2b_stall: got %0d/%0d cycles required 3/2", st1, st2);
        end
        total++;
        if (obs_addr !== 32'h44 || obs_wdata !== 32'h5555_0000 || obs_we !== 1'b1) begin
            bad++;
            $display("FAIL b2b_bus: addr=%h wdata=%h we=%b required 44/55550000/1", obs_addr, obs_wdata, obs_we);
        end
        total++;
        if (sb.size() !== 0 || BusErr !== 1'b1) begin
            bad++;
            $display("FAIL b2b_state: pending=%0d err=%b required 0/1", sb.size(), BusErr);
        end
    endtask

    task automatic test_stray_ack_reset();
        int st;
        @(negedge clk);
        stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        #1;
        total++;
        if (bus.req !== 1'b0 || StallM !== 1'b0) begin
            bad++;
            $display("FAIL stray_ack: req=%b stall=%b required 0/0", bus.req, StallM);
        end
        @(negedge clk);
        ack_delay = 0;
        RegWriteM = 1'b1; ResultSrcM = 1'b1; ALUResultM = 32'h80; RdM = 5'd12;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        set_idle();
        #1;
        total++;
        if (bus.req !== 1'b0 || StallM !== 1'b0 || RegWriteW !== 1'b0 || RdW !== 5'd0 ||
            ReadDataW !== '0 || BusErr !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: req=%b stall=%b rw=%b rd=%0d rdata=%h err=%b required all zero",
                     bus.req, StallM, RegWriteW, RdW, ReadDataW, BusErr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_rdq = '0;
        model_rdw = '0;
        run_instr(1'b1, 1'b1, 1'b0, 32'h84, 32'h0, 5'd13, 1, 32'h1357_9BDF, st);
        total++;
        if (st !== 2) begin
            bad++;
            $display("FAIL post_reset_stall: got %0d cycles required 2", st);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_timeout();
        test_back_to_back();
        test_stray_ack_reset();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1);
    end

endmodule
